// File: rtl/syn_gpu_pkg.sv
// Shared mulberry-side GPU types: MID encoding plus the random-arbiter state
// enum and its default WAIT timeout.
package syn_gpu_pkg;

    typedef logic [3:0] mid_t;
    localparam mid_t MID_IDLE = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } rand_arb_state_t;

    localparam int RAND_ARB_TIMEOUT_DEF = 64;

endpackage

// File: rtl/syn_gpu_rand_arb_if.sv
// Requester and generator side signals of the shared random-number arbiter.
//
// Handshake: a requester raises req_valid with a stable req_mid and holds both
// until it sees its req_ack bit (a one-cycle pulse). It may drop req_valid on
// the cycle after that. The result comes back later as a one-cycle rsp_valid
// bit. rsp_data is meaningful only in that cycle. The generator takes a
// request on every cycle in which rand_req_mid != MID_IDLE. It answers by
// placing the same MID on rand_rsp_mid together with rand_rsp_data.
interface syn_gpu_rand_arb_if
    import syn_gpu_pkg::*;
#(
    parameter int P_NUM_REQ = 4,
    parameter int P_MID_W   = $bits(mid_t),
    parameter int P_DATA_W  = 32
);
    logic [P_NUM_REQ-1:0]         req_valid;
    logic [P_NUM_REQ*P_MID_W-1:0] req_mid;
    logic [P_NUM_REQ-1:0]         req_ack;
    logic [P_NUM_REQ-1:0]         rsp_valid;
    logic [P_DATA_W-1:0]          rsp_data;
    logic [P_MID_W-1:0]           rand_req_mid;
    logic                         rand_busy;
    logic [P_MID_W-1:0]           rand_rsp_mid;
    logic [P_DATA_W-1:0]          rand_rsp_data;
    logic                         err_timeout;
    logic                         err_bad_mid;

    modport slave (
        input  req_valid, req_mid, rand_busy, rand_rsp_mid, rand_rsp_data,
        output req_ack, rsp_valid, rsp_data, rand_req_mid, err_timeout, err_bad_mid
    );

    modport master (
        output req_valid, req_mid, rand_busy, rand_rsp_mid, rand_rsp_data,
        input  req_ack, rsp_valid, rsp_data, rand_req_mid, err_timeout, err_bad_mid
    );
endinterface

// File: rtl/syn_gpu_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping
// modulo P_NUM_REQ. Returns a one-hot grant and its index.
module syn_gpu_rr_arb #(
    parameter int P_NUM_REQ = 4,
    parameter int P_IDX_W   = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [P_IDX_W-1:0]   ptr,
    output logic [P_NUM_REQ-1:0] grant,
    output logic [P_IDX_W-1:0]   idx,
    output logic                 any
);
    logic           found;
    logic [P_IDX_W:0] k;

    assign any = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            k = {1'b0, ptr} + (P_IDX_W + 1)'(i);
            if (k >= (P_IDX_W + 1)'(P_NUM_REQ)) begin
                k = k - (P_IDX_W + 1)'(P_NUM_REQ);
            end
            if (!found && req[k[P_IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[k[P_IDX_W-1:0]]   = 1'b1;
                idx                     = k[P_IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/syn_gpu_rand_arb.sv
// Round-robin sharing of the single PRBS31 generator between P_NUM_REQ GPU
// requesters: one outstanding generator transaction at a time, all outputs registered.
module syn_gpu_rand_arb
    import syn_gpu_pkg::*;
#(
    parameter int P_NUM_REQ = 4,
    parameter int P_MID_W   = $bits(mid_t),
    parameter int P_DATA_W  = 32,
    parameter int P_TIMEOUT = RAND_ARB_TIMEOUT_DEF
) (
    input  logic                           clk_ir,
    input  logic                           rst_sync,
    syn_gpu_rand_arb_if.slave              bus,
    output rand_arb_state_t                dbg_state,
    output logic [$clog2(P_NUM_REQ)-1:0]   dbg_rr_ptr
);
    localparam int IDX_W = $clog2(P_NUM_REQ);
    localparam int CNT_W = $clog2(P_TIMEOUT);
    localparam logic [P_MID_W-1:0] L_MID_IDLE = P_MID_W'(MID_IDLE);

    rand_arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]       g_idx, g_idx_nxt;
    logic [P_MID_W-1:0]     lat_mid, lat_mid_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [P_NUM_REQ-1:0]   ack_q, ack_nxt;
    logic [P_NUM_REQ-1:0]   rsp_valid_q, rsp_valid_nxt;
    logic [P_DATA_W-1:0]    rsp_data_q, rsp_data_nxt;
    logic [P_MID_W-1:0]     rand_req_q, rand_req_nxt;
    logic                   err_to_q, err_to_nxt;
    logic                   err_bad_q, err_bad_nxt;

    logic [P_NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [P_MID_W-1:0]     pick_mid;

    syn_gpu_rr_arb #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_IDX_W   (IDX_W)
    ) u_rr_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_mid = bus.req_mid[int'(pick_idx) * P_MID_W +: P_MID_W];

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g_idx       <= '0;
            lat_mid     <= L_MID_IDLE;
            cnt         <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rand_req_q  <= L_MID_IDLE;
            err_to_q    <= 1'b0;
            err_bad_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            g_idx       <= g_idx_nxt;
            lat_mid     <= lat_mid_nxt;
            cnt         <= cnt_nxt;
            ack_q       <= ack_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
            rand_req_q  <= rand_req_nxt;
            err_to_q    <= err_to_nxt;
            err_bad_q   <= err_bad_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        g_idx_nxt     = g_idx;
        lat_mid_nxt   = lat_mid;
        cnt_nxt       = cnt;
        ack_nxt       = '0;
        rsp_valid_nxt = '0;
        rsp_data_nxt  = '0;
        rand_req_nxt  = L_MID_IDLE;
        err_to_nxt    = 1'b0;
        err_bad_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // Skip the cycle our own ack is visible so a requester still
                // holding req_valid then cannot be granted twice.
                if (!bus.rand_busy && pick_any && (ack_q == '0)) begin
                    ack_nxt     = pick_grant;
                    g_idx_nxt   = pick_idx;
                    lat_mid_nxt = pick_mid;
                    rr_ptr_nxt  = (pick_idx == IDX_W'(P_NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (pick_mid == L_MID_IDLE) begin
                        err_bad_nxt = 1'b1;
                    end else begin
                        rand_req_nxt = pick_mid;
                        state_nxt    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A match in the timeout cycle still delivers the response.
                if (bus.rand_rsp_mid == lat_mid) begin
                    rsp_valid_nxt[g_idx] = 1'b1;
                    rsp_data_nxt         = bus.rand_rsp_data;
                    state_nxt            = IDLE;
                end else if (cnt == CNT_W'(P_TIMEOUT - 1)) begin
                    err_to_nxt = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ack      = ack_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rand_req_mid = rand_req_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_bad_mid  = err_bad_q;
    assign dbg_state        = state;
    assign dbg_rr_ptr       = rr_ptr;
endmodule

// File: tb/tb_syn_gpu_rand_arb.sv
// Directed bench for syn_gpu_rand_arb with four requesters and a hand-driven
// generator model; expected values are computed by hand in each scenario task.
module tb_syn_gpu_rand_arb;
    import syn_gpu_pkg::*;

    logic            clk;
    logic            rst;
    rand_arb_state_t dbg_state;
    logic [1:0]      dbg_rr_ptr;
    int              checks;
    int              errors;

    syn_gpu_rand_arb_if #(.P_NUM_REQ(4), .P_MID_W(4), .P_DATA_W(32)) bus ();

    syn_gpu_rand_arb #(
        .P_NUM_REQ (4),
        .P_MID_W   (4),
        .P_DATA_W  (32),
        .P_TIMEOUT (64)
    ) dut (
        .clk_ir     (clk),
        .rst_sync   (rst),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.req_valid      = '0;
        bus.req_mid        = '0;
        bus.rand_busy      = 1'b0;
        bus.rand_rsp_mid   = '0;
        bus.rand_rsp_data  = '0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver helpers ----------------
    task automatic set_mids(input logic [3:0] m0, input logic [3:0] m1,
                            input logic [3:0] m2, input logic [3:0] m3);
        bus.req_mid = {m3, m2, m1, m0};
    endtask

    task automatic gen_respond(input logic [3:0] mid, input logic [31:0] data);
        bus.rand_rsp_mid  = mid;
        bus.rand_rsp_data = data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        checks++; if (dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dbg_rr_ptr); end
        checks++; if (bus.req_ack !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_ack_rsp: ack %b rsp %b expected 0000 0000", bus.req_ack, bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'd0 || bus.rand_req_mid !== 4'd0) begin errors++; $display("FAIL reset_data_mid: data %h mid %0d expected 0 0", bus.rsp_data, bus.rand_req_mid); end
        checks++; if (bus.err_timeout !== 1'b0 || bus.err_bad_mid !== 1'b0) begin errors++; $display("FAIL reset_err: to %b bad %b expected 0 0", bus.err_timeout, bus.err_bad_mid); end
    endtask

    task automatic test_single();
        bit quiet_ok;
        do_reset();
        set_mids(4'd0, 4'd3, 4'd0, 4'd0);
        bus.req_valid = 4'b0010;
        tick();
        checks++; if (bus.req_ack !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b expected 0010", bus.req_ack); end
        checks++; if (bus.rand_req_mid !== 4'd3 || dbg_state !== ISSUE) begin errors++; $display("FAIL single_issue: mid %0d state %0d expected 3 %0d", bus.rand_req_mid, dbg_state, ISSUE); end
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rand_req_mid !== 4'd0 || bus.req_ack !== 4'b0000 || dbg_state !== WAIT) begin errors++; $display("FAIL single_wait: mid %0d ack %b state %0d expected 0 0000 %0d", bus.rand_req_mid, bus.req_ack, dbg_state, WAIT); end
        quiet_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid !== 4'b0000 || bus.rand_req_mid !== 4'd0) quiet_ok = 1'b0;
        end
        checks++; if (quiet_ok !== 1'b1) begin errors++; $display("FAIL single_quiet: got %b expected 1", quiet_ok); end
        gen_respond(4'd3, 32'h1234_5678);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL single_rsp: valid %b data %h expected 0010 12345678", bus.rsp_valid, bus.rsp_data); end
        gen_respond(4'd0, 32'd0);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000 || dbg_state !== IDLE) begin errors++; $display("FAIL single_rsp_pulse: valid %b state %0d expected 0000 %0d", bus.rsp_valid, dbg_state, IDLE); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_oh;
        logic [3:0]  exp_mid;
        logic [31:0] exp_data;
        do_reset();
        set_mids(4'd1, 4'd2, 4'd3, 4'd4);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            exp_oh   = 4'b0001 << (n % 4);
            exp_mid  = 4'((n % 4) + 1);
            exp_data = 32'h0A00_0000 + 32'(n);
            tick();
            checks++; if (bus.req_ack !== exp_oh || bus.rand_req_mid !== exp_mid) begin errors++; $display("FAIL rr_grant_%0d: ack %b mid %0d expected %b %0d", n, bus.req_ack, bus.rand_req_mid, exp_oh, exp_mid); end
            tick();
            gen_respond(exp_mid, exp_data);
            checks++; if (bus.req_ack !== 4'b0000) begin errors++; $display("FAIL rr_outstanding_%0d: ack %b expected 0000", n, bus.req_ack); end
            tick();
            checks++; if (bus.rsp_valid !== exp_oh || bus.rsp_data !== exp_data) begin errors++; $display("FAIL rr_rsp_%0d: valid %b data %h expected %b %h", n, bus.rsp_valid, bus.rsp_data, exp_oh, exp_data); end
            gen_respond(4'd0, 32'd0);
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_busy();
        bit quiet_ok;
        do_reset();
        bus.rand_busy = 1'b1;
        set_mids(4'd2, 4'd0, 4'd0, 4'd0);
        bus.req_valid = 4'b0001;
        quiet_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.req_ack !== 4'b0000 || bus.rand_req_mid !== 4'd0) quiet_ok = 1'b0;
        end
        checks++; if (quiet_ok !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b expected 1", quiet_ok); end
        bus.rand_busy = 1'b0;
        tick();
        checks++; if (bus.req_ack !== 4'b0001 || bus.rand_req_mid !== 4'd2) begin errors++; $display("FAIL busy_release: ack %b mid %0d expected 0001 2", bus.req_ack, bus.rand_req_mid); end
        bus.req_valid = 4'b0000;
        tick();
        gen_respond(4'd2, 32'h0000_BEEF);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h0000_BEEF) begin errors++; $display("FAIL busy_rsp: valid %b data %h expected 0001 0000beef", bus.rsp_valid, bus.rsp_data); end
        gen_respond(4'd0, 32'd0);
    endtask

    task automatic test_timeout();
        bit quiet_ok;
        do_reset();
        set_mids(4'd1, 4'd0, 4'd3, 4'd0);
        bus.req_valid = 4'b0101;
        tick();
        checks++; if (bus.req_ack !== 4'b0001) begin errors++; $display("FAIL to_first_ack: got %b expected 0001", bus.req_ack); end
        bus.req_valid = 4'b0100;
        tick();
        quiet_ok = 1'b1;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus.err_timeout !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.req_ack !== 4'b0000) quiet_ok = 1'b0;
        end
        checks++; if (quiet_ok !== 1'b1) begin errors++; $display("FAIL to_early: got %b expected 1", quiet_ok); end
        tick();
        checks++; if (bus.err_timeout !== 1'b1 || bus.rsp_valid !== 4'b0000 || dbg_state !== IDLE) begin errors++; $display("FAIL to_pulse: err %b rsp %b state %0d expected 1 0000 %0d", bus.err_timeout, bus.rsp_valid, dbg_state, IDLE); end
        tick();
        checks++; if (bus.err_timeout !== 1'b0 || bus.req_ack !== 4'b0100 || bus.rand_req_mid !== 4'd3) begin errors++; $display("FAIL to_next_grant: err %b ack %b mid %0d expected 0 0100 3", bus.err_timeout, bus.req_ack, bus.rand_req_mid); end
        bus.req_valid = 4'b0000;
        tick();
        gen_respond(4'd3, 32'h0055_AA00);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'h0055_AA00) begin errors++; $display("FAIL to_next_rsp: valid %b data %h expected 0100 0055aa00", bus.rsp_valid, bus.rsp_data); end
        gen_respond(4'd0, 32'd0);
    endtask

    task automatic test_wrong_mid();
        do_reset();
        set_mids(4'd3, 4'd0, 4'd0, 4'd0);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        gen_respond(4'd5, 32'h0BAD_0BAD);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000 || dbg_state !== WAIT) begin errors++; $display("FAIL wrong_mid_ignored: valid %b state %0d expected 0000 %0d", bus.rsp_valid, dbg_state, WAIT); end
        gen_respond(4'd3, 32'h0600_D00D);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'h0600_D00D) begin errors++; $display("FAIL wrong_mid_match: valid %b data %h expected 0001 0600d00d", bus.rsp_valid, bus.rsp_data); end
        gen_respond(4'd0, 32'd0);
    endtask

    task automatic test_bad_mid();
        do_reset();
        set_mids(4'd0, 4'd0, 4'd0, 4'd0);
        bus.req_valid = 4'b0010;
        tick();
        checks++; if (bus.req_ack !== 4'b0010 || bus.err_bad_mid !== 1'b1) begin errors++; $display("FAIL bad_mid_ack: ack %b err %b expected 0010 1", bus.req_ack, bus.err_bad_mid); end
        checks++; if (bus.rand_req_mid !== 4'd0 || dbg_state !== IDLE || dbg_rr_ptr !== 2'd2) begin errors++; $display("FAIL bad_mid_idle: mid %0d state %0d ptr %0d expected 0 %0d 2", bus.rand_req_mid, dbg_state, dbg_rr_ptr, IDLE); end
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.err_bad_mid !== 1'b0 || bus.req_ack !== 4'b0000) begin errors++; $display("FAIL bad_mid_pulse: err %b ack %b expected 0 0000", bus.err_bad_mid, bus.req_ack); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_mids(4'd0, 4'd0, 4'd6, 4'd0);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        checks++; if (dbg_state !== WAIT || dbg_rr_ptr !== 2'd3) begin errors++; $display("FAIL rst_pre: state %0d ptr %0d expected %0d 3", dbg_state, dbg_rr_ptr, WAIT); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dbg_state !== IDLE || dbg_rr_ptr !== 2'd0 || bus.req_ack !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_state: state %0d ptr %0d ack %b rsp %b expected %0d 0 0000 0000", dbg_state, dbg_rr_ptr, bus.req_ack, bus.rsp_valid, IDLE); end
        gen_respond(4'd6, 32'h0000_0666);
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_late_rsp: valid %b expected 0000", bus.rsp_valid); end
        gen_respond(4'd0, 32'd0);
        set_mids(4'd1, 4'd0, 4'd0, 4'd7);
        bus.req_valid = 4'b1001;
        tick();
        checks++; if (bus.req_ack !== 4'b0001 || bus.rand_req_mid !== 4'd1) begin errors++; $display("FAIL rst_rr_restart: ack %b mid %0d expected 0001 1", bus.req_ack, bus.rand_req_mid); end
        bus.req_valid = 4'b0000;
        do_reset();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_timeout();
        test_wrong_mid();
        test_bad_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
